// File: rtl/pwm_capture.sv
// PWM input capture: measures period and high time of pwm_in in clk cycles, exposed over a
// single-cycle-ack mem_valid/mem_ready slave with W1C status flags and a level interrupt.
module pwm_capture #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  input  logic        pwm_in,
  output logic        irq
);

  typedef enum logic [1:0] {IDLE, WAIT_RISE, MEASURE} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_d, rise, fall;
  logic [CNT_W-1:0]       cnt, cnt_nxt, high_lat, high_lat_nxt;
  logic                   res_load, ovf_set;
  logic                   en, irq_en, valid, ovf;
  logic [15:0]            period, high;
  logic                   acc, wr0;
  logic [1:0]             reg_sel;
  logic [31:0]            rd_val;
  logic                   unused_bits;

  assign unused_bits = ^{mem_addr[31:4], mem_addr[1:0], mem_wdata[31:2], mem_wstrb[3:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync   <= '0;
      sync_d <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], pwm_in};
      sync_d <= sync[SYNC_STAGES-1];
    end
  end

  assign rise = sync[SYNC_STAGES-1] & ~sync_d;
  assign fall = ~sync[SYNC_STAGES-1] & sync_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      high_lat <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      high_lat <= high_lat_nxt;
    end
  end

  // Both edges see the same synchronizer delay, so cnt=1 on the cycle after a rise
  // makes PERIOD and HIGH exact cycle counts.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    high_lat_nxt = high_lat;
    res_load     = 1'b0;
    ovf_set      = 1'b0;
    if (!en) begin
      state_nxt    = IDLE;
      cnt_nxt      = '0;
      high_lat_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt    = WAIT_RISE;
          cnt_nxt      = '0;
          high_lat_nxt = '0;
        end
        WAIT_RISE: begin
          if (rise) begin
            state_nxt    = MEASURE;
            cnt_nxt      = CNT_W'(1);
            high_lat_nxt = '0;
          end
        end
        MEASURE: begin
          if (rise) begin
            res_load     = 1'b1;
            cnt_nxt      = CNT_W'(1);
            high_lat_nxt = '0;
          end else if (cnt == '1) begin
            ovf_set      = 1'b1;
            state_nxt    = WAIT_RISE;
            cnt_nxt      = '0;
            high_lat_nxt = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
            if (fall) high_lat_nxt = cnt;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign acc     = mem_valid & ~mem_ready;
  assign wr0     = acc & mem_wstrb[0];
  assign reg_sel = mem_addr[3:2];

  always_comb begin
    rd_val = '0;
    case (reg_sel)
      2'd0:    rd_val = {30'd0, irq_en, en};
      2'd1:    rd_val = {30'd0, ovf, valid};
      2'd2:    rd_val = {high, period};
      default: rd_val = '0;
    endcase
  end

  // Hardware set is OR-ed in after the W1C mask so a same-cycle set wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en        <= 1'b0;
      irq_en    <= 1'b0;
      valid     <= 1'b0;
      ovf       <= 1'b0;
      period    <= '0;
      high      <= '0;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      irq       <= 1'b0;
    end else begin
      if (wr0 && reg_sel == 2'd0) begin
        en     <= mem_wdata[0];
        irq_en <= mem_wdata[1];
      end
      valid <= (valid & ~(wr0 && reg_sel == 2'd1 && mem_wdata[0])) | res_load;
      ovf   <= (ovf & ~(wr0 && reg_sel == 2'd1 && mem_wdata[1])) | ovf_set;
      if (res_load) begin
        period <= 16'(cnt);
        high   <= 16'(high_lat);
      end
      mem_ready <= acc;
      mem_rdata <= acc ? rd_val : 32'd0;
      irq       <= irq_en & (valid | ovf);
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: register table, period/high measurement, overflow,
// enable abort and asynchronous reset.
module tb_pwm_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        pwm_in;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  bit pwm_run = 0;
  int hi_len  = 32;
  int lo_len  = 96;
  int ph      = 0;

  pwm_capture #(.CNT_W(16), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata),
    .pwm_in    (pwm_in),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  // Waveform source: hi_len cycles high, then lo_len cycles low.
  initial begin
    pwm_in = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!pwm_run) begin
        pwm_in = 1'b0;
        ph     = 0;
      end else begin
        pwm_in = (ph < hi_len);
        ph     = (ph + 1 >= hi_len + lo_len) ? 0 : ph + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called #1 after a rising edge; checks one-cycle ack latency and a single-cycle pulse.
  task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] r);
    int n;
    n         = 0;
    mem_addr  = a;
    mem_wdata = d;
    mem_wstrb = s;
    mem_valid = 1'b1;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!mem_ready && n < 16);
    r = mem_rdata;
    check("ack_latency", n, 1);
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    @(posedge clk);
    #1;
    check("ack_single_pulse", {31'd0, mem_ready}, 0);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
    logic [31:0] r;
    bus(a, 32'd0, 4'h0, r);
    check(name, r, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    bus(a, d, 4'hF, r);
  endtask

  task automatic wait_irq(input int bound, input string name);
    int n;
    n = 0;
    while (!irq && n < bound) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, {31'd0, irq}, 1);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    bit          chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  initial begin
    logic [31:0] r;

    vecs[0]  = '{32'h0, 32'h0,         4'h0, 1'b1, 32'h0};
    vecs[1]  = '{32'h4, 32'h0,         4'h0, 1'b1, 32'h0};
    vecs[2]  = '{32'h8, 32'h0,         4'h0, 1'b1, 32'h0};
    vecs[3]  = '{32'hC, 32'h0,         4'h0, 1'b1, 32'h0};
    vecs[4]  = '{32'h0, 32'hFFFF_FFFF, 4'hE, 1'b0, 32'h0};
    vecs[5]  = '{32'h0, 32'h0,         4'h0, 1'b1, 32'h0};
    vecs[6]  = '{32'h0, 32'hFFFF_FFFE, 4'h1, 1'b0, 32'h0};
    vecs[7]  = '{32'h0, 32'hFFFF_FFFF, 4'h0, 1'b1, 32'h2};
    vecs[8]  = '{32'hC, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0};
    vecs[9]  = '{32'hC, 32'h0,         4'h0, 1'b1, 32'h0};
    vecs[10] = '{32'h8, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0};
    vecs[11] = '{32'h8, 32'h0,         4'h0, 1'b1, 32'h0};
    vecs[12] = '{32'h4, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0};
    vecs[13] = '{32'h0, 32'h0,         4'hF, 1'b1, 32'h2};

    rst       = 1'b1;
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    #1;
    check("reset_ready", {31'd0, mem_ready}, 0);
    check("reset_rdata", mem_rdata, 0);
    check("reset_irq", {31'd0, irq}, 0);
    cyc(3);
    rst = 1'b0;
    cyc(1);

    // Register map table; entry 13 writes CTRL=0 and reads back the pre-write value.
    for (int i = 0; i < 14; i++) begin
      bus(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, r);
      if (vecs[i].chk) check($sformatf("vec%0d", i), r, vecs[i].exp);
    end
    rd(32'h0, 32'h0, "ctrl_cleared");

    // 0x20 high / 0x60 low
    wr(32'h0, 32'h3);
    hi_len  = 32;
    lo_len  = 96;
    pwm_run = 1;
    wait_irq(600, "first_result_irq");
    rd(32'h4, 32'h1, "status_valid");
    rd(32'h8, 32'h0020_0080, "result_32_96");
    wr(32'h4, 32'h1);
    cyc(1);
    check("irq_after_w1c", {31'd0, irq}, 0);
    rd(32'h4, 32'h0, "status_cleared");

    // 0x40 / 0x40 overwrites RESULT with VALID held
    hi_len = 64;
    lo_len = 64;
    cyc(400);
    rd(32'h8, 32'h0040_0080, "result_64_64");
    rd(32'h4, 32'h1, "valid_kept");

    // Constant low input overflows the counter
    pwm_run = 0;
    cyc(10);
    wr(32'h4, 32'h1);
    rd(32'h4, 32'h0, "status_before_ovf");
    check("irq_before_ovf", {31'd0, irq}, 0);
    wait_irq(70000, "ovf_irq");
    rd(32'h4, 32'h2, "status_ovf");
    rd(32'h8, 32'h0040_0080, "result_kept_on_ovf");
    wr(32'h4, 32'h2);
    rd(32'h4, 32'h0, "ovf_cleared");
    check("irq_after_ovf_clear", {31'd0, irq}, 0);

    // Enable mid-period: first result must be a whole period
    wr(32'h0, 32'h2);
    hi_len  = 32;
    lo_len  = 96;
    pwm_run = 1;
    cyc(60);
    wr(32'h0, 32'h3);
    wait_irq(400, "reenable_irq");
    rd(32'h8, 32'h0020_0080, "result_after_enable");
    wr(32'h4, 32'h1);
    cyc(40);
    wr(32'h0, 32'h2);
    cyc(30);
    rd(32'h4, 32'h0, "no_result_while_disabled");
    wr(32'h0, 32'h3);
    wait_irq(400, "abort_irq");
    rd(32'h8, 32'h0020_0080, "result_after_abort");

    // Asynchronous reset while an ack is on the bus
    mem_addr  = 32'h8;
    mem_wstrb = 4'h0;
    mem_valid = 1'b1;
    @(posedge clk);
    #1;
    check("pre_rst_ready", {31'd0, mem_ready}, 1);
    check("pre_rst_rdata", mem_rdata, 32'h0020_0080);
    check("pre_rst_irq", {31'd0, irq}, 1);
    mem_valid = 1'b0;
    rst       = 1'b1;
    #2;
    check("rst_ready", {31'd0, mem_ready}, 0);
    check("rst_rdata", mem_rdata, 0);
    check("rst_irq", {31'd0, irq}, 0);
    cyc(2);
    rst = 1'b0;
    cyc(1);
    rd(32'h0, 32'h0, "ctrl_after_rst");
    rd(32'h4, 32'h0, "status_after_rst");
    rd(32'h8, 32'h0, "result_after_rst");
    wr(32'h8, 32'hDEAD_BEEF);
    rd(32'h8, 32'h0, "result_write_ignored");
    bus(32'h0, 32'hFFFF_FFFF, 4'h0, r);
    rd(32'h0, 32'h0, "read_no_side_effect");
    cyc(300);
    rd(32'h4, 32'h0, "no_measure_without_en");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
